// File: rtl/wb_shared_arbiter.sv
// Two-master Wibone arbiter for one shared slave: round-robin grant,
// cycle-locked ownership, and a wait-state watchdog that error-acks stalls.
module wb_shared_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_sel_i,
  input  logic [63:0] m_adr_i,
  input  logic [63:0] m_dat_i,
  output logic [1:0]  m_ack_o,
  output logic [63:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        last_q;
  logic [15:0] cnt_q;

  logic [1:0]  req;
  logic        gnt;
  logic        sel1;
  logic        cyc_m;
  logic        stb_m;
  logic        we_m;
  logic [3:0]  sel_m;
  logic [31:0] adr_m;
  logic [31:0] dat_m;
  logic [31:0] rd;
  logic        to_hit;

  assign req   = m_cyc_i & m_stb_i;
  assign gnt   = |grant_q;
  assign sel1  = grant_q[1];
  assign cyc_m = sel1 ? m_cyc_i[1] : m_cyc_i[0];
  assign stb_m = sel1 ? m_stb_i[1] : m_stb_i[0];
  assign we_m  = sel1 ? m_we_i[1]  : m_we_i[0];
  assign sel_m = sel1 ? m_sel_i[7:4]   : m_sel_i[3:0];
  assign adr_m = sel1 ? m_adr_i[63:32] : m_adr_i[31:0];
  assign dat_m = sel1 ? m_dat_i[63:32] : m_dat_i[31:0];

  // A real slave ack in the expiry cycle wins over the watchdog
  assign to_hit = gnt & stb_m & ~s_ack_i & (cnt_q == TO_CNT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req[0] && (!req[1] || last_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
            last_q  <= 1'b0;
          end else if (req[1]) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
            last_q  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!cyc_m) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
          if (s_ack_i || to_hit) begin
            cnt_q <= '0;
          end else if (stb_m) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign s_cyc_o = gnt & cyc_m;
  assign s_stb_o = gnt & stb_m & ~to_hit;
  assign s_we_o  = gnt & we_m;
  assign s_sel_o = gnt ? sel_m : 4'h0;
  assign s_adr_o = gnt ? adr_m : 32'h0;
  assign s_dat_o = gnt ? dat_m : 32'h0;

  assign rd        = to_hit ? ERR_DATA : s_dat_i;
  assign m_ack_o   = (s_ack_i | to_hit) ? grant_q : 2'b00;
  assign m_dat_o   = {grant_q[1] ? rd : 32'h0, grant_q[0] ? rd : 32'h0};
  assign grant_o   = grant_q;
  assign timeout_o = to_hit;

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Bench for wb_shared_arbiter: table of single transfers checked through an
// expected-response queue, plus scripted arbitration/burst/reset sequences.
module tb_wb_shared_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_adr_i, m_dat_i;
  logic [1:0]  m_ack_o;
  logic [63:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  wb_shared_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_sel_i  (m_sel_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_ack_o  (m_ack_o),
    .m_dat_o  (m_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack_i),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic        m;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          ack_dly;
    logic [31:0] sdat;
    logic [31:0] exp_dat;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic        m;
    logic [31:0] dat;
    logic        to;
  } exp_t;

  int   nvec  = 0;
  int   nfail = 0;
  exp_t sbq[$];
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb,
                     input logic we, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_sel_i[m*4 +: 4]   = sel;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = dat;
  endtask

  function automatic logic [1:0] oh(input logic m);
    return m ? 2'b10 : 2'b01;
  endfunction

  task automatic xfer(input vec_t v);
    exp_t        e;
    int          k;
    bit          done;
    logic [63:0] exp64;
    drv(int'(v.m), 1'b1, 1'b1, v.we, v.sel, v.adr, v.wdat);
    e.m   = v.m;
    e.dat = v.exp_dat;
    e.to  = v.exp_to;
    sbq.push_back(e);
    tick();
    smp();
    chk("grant", 64'(grant_o), 64'(oh(v.m)));
    chk("s_adr", 64'(s_adr_o), 64'(v.adr));
    chk("s_we", 64'(s_we_o), 64'(v.we));
    chk("s_sel", 64'(s_sel_o), 64'(v.sel));
    chk("s_dat", 64'(s_dat_o), 64'(v.wdat));
    k    = 0;
    done = 0;
    while (!done && k < 40) begin
      if (k == v.ack_dly) begin
        s_ack_i = 1'b1;
        s_dat_i = v.sdat;
      end else begin
        s_ack_i = 1'b0;
        s_dat_i = 32'h5555_AAAA ^ 32'(k);
      end
      #1;
      if (m_ack_o != 2'b00) begin
        done = 1;
        if (sbq.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL sb_empty: got ack %b expected none", m_ack_o);
        end else begin
          e     = sbq.pop_front();
          exp64 = e.m ? {e.dat, 32'h0} : {32'h0, e.dat};
          chk("ack", 64'(m_ack_o), 64'(oh(e.m)));
          chk("rdata", m_dat_o, exp64);
          chk("timeout", 64'(timeout_o), 64'(e.to));
          chk("s_stb", 64'(s_stb_o), 64'(!e.to));
          chk("ack_cyc", 64'(k), 64'(v.exp_to ? TO : v.ack_dly));
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) begin
      nvec++;
      nfail++;
      $display("FAIL ack_wait: got no ack in %0d cycles expected one", k);
    end
    tick();
    s_ack_i = 1'b0;
    smp();
    chk("ack_1cyc", 64'(m_ack_o), 64'(0));
    chk("to_1cyc", 64'(timeout_o), 64'(0));
    tick();
    drv(int'(v.m), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    smp();
    chk("bubble", 64'(grant_o), 64'(0));
  endtask

  task automatic beat_release(input logic m);
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_1111;
    #1;
    chk("rr_ack", 64'(m_ack_o), 64'(oh(m)));
    tick();
    s_ack_i = 1'b0;
    drv(int'(m), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    smp();
    chk("rr_idle", 64'(grant_o), 64'(0));
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 2,
               32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h3, 32'h2000_0004, 32'hA5A5_5A5A, 0,
               32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'hF, 32'h2000_0008, 32'h0F0F_F0F0, 99,
               32'h0, ERR, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'hC, 32'h1000_0010, 32'h0, TO,
               32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 4'h1, 32'h1000_0014, 32'h0, TO - 1,
               32'h8765_4321, 32'h8765_4321, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'hF, 32'h2000_0020, 32'h0, 5,
               32'h1357_9BDF, 32'h1357_9BDF, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'hF, 32'h1000_0040, 32'h7777_8888, 99,
               32'h0, ERR, 1'b1};

    wb_rst_i = 1'b1;
    m_cyc_i  = '0;
    m_stb_i  = '0;
    m_we_i   = '0;
    m_sel_i  = '0;
    m_adr_i  = '0;
    m_dat_i  = '0;
    s_ack_i  = 1'b0;
    s_dat_i  = '0;
    tick();
    tick();
    wb_rst_i = 1'b0;
    smp();
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_scyc", 64'(s_cyc_o), 64'(0));
    chk("rst_to", 64'(timeout_o), 64'(0));
    s_ack_i = 1'b1;
    s_dat_i = 32'hFFFF_0000;
    #1;
    chk("idle_ack", 64'(m_ack_o), 64'(0));
    chk("idle_dat", m_dat_o, 64'(0));
    s_ack_i = 1'b0;

    // Simultaneous requests from reset: m0, m1, m0, m1 with bubbles
    drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'hA000_0000, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hB000_0000, 32'h0);
    tick();
    smp();
    chk("rr1", 64'(grant_o), 64'(2'b01));
    beat_release(1'b0);
    tick();
    smp();
    chk("rr2", 64'(grant_o), 64'(2'b10));
    beat_release(1'b1);
    drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'hA000_0004, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hB000_0004, 32'h0);
    tick();
    smp();
    chk("rr3", 64'(grant_o), 64'(2'b01));
    beat_release(1'b0);
    tick();
    smp();
    chk("rr4", 64'(grant_o), 64'(2'b10));
    beat_release(1'b1);

    foreach (tbl[i]) xfer(tbl[i]);

    // m1 burst holds the bus while m0 waits
    drv(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hB000_0100, 32'h1111_2222);
    tick();
    smp();
    chk("bst_gnt", 64'(grant_o), 64'(2'b10));
    drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'hA000_0100, 32'h0);
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      #1;
      chk("bst_ack", 64'(m_ack_o), 64'(2'b10));
      chk("bst_lock", 64'(grant_o), 64'(2'b10));
      s_ack_i = 1'b0;
      @(negedge clk);
    end
    tick();
    drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    smp();
    chk("bst_hold", 64'(grant_o), 64'(2'b10));
    tick();
    smp();
    chk("bst_gap", 64'(grant_o), 64'(0));
    tick();
    smp();
    chk("bst_m0", 64'(grant_o), 64'(2'b01));
    tick();
    drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    smp();
    chk("bst_end", 64'(grant_o), 64'(0));

    // Master abandons a stalled transfer
    drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hB000_0200, 32'h0);
    tick();
    smp();
    chk("drop_gnt", 64'(grant_o), 64'(2'b10));
    repeat (3) @(negedge clk);
    tick();
    drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    smp();
    chk("drop_ack", 64'(m_ack_o), 64'(0));
    tick();
    smp();
    chk("drop_idle", 64'(grant_o), 64'(0));
    repeat (8) @(negedge clk);
    chk("drop_to", 64'(timeout_o), 64'(0));

    // Reset during a granted wait
    drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'hA000_0300, 32'h0);
    tick();
    smp();
    chk("rw_gnt", 64'(grant_o), 64'(2'b01));
    repeat (3) @(negedge clk);
    tick();
    wb_rst_i = 1'b1;
    drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hB000_0300, 32'h0);
    tick();
    wb_rst_i = 1'b0;
    smp();
    chk("rw_grant", 64'(grant_o), 64'(0));
    chk("rw_scyc", 64'(s_cyc_o), 64'(0));
    chk("rw_ack", 64'(m_ack_o), 64'(0));
    tick();
    smp();
    chk("rw_rearb", 64'(grant_o), 64'(2'b01));

    if (sbq.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL sb_left: got %0d pending expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
